// File: rtl/hdp_line_streamer.sv
// SPI pixel feed -> ring of NUM_BUFFERS line buffers -> fixed-cadence HDP packet stream.
// Define HDP_STREAMER_BLANK_FILL_EN to emit a black line on underrun instead of stalling.
module hdp_line_streamer #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_LINE  = 40,
  parameter int BLANK_PER_LINE  = 4,
  parameter int LINES_PER_FRAME = 1280,
  parameter int BACK_PORCH      = 24,
  parameter int UPDATE_CYCLES   = 28,
  parameter int NUM_BUFFERS     = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_sck,
  input  logic                         i_mosi,
  input  logic                         i_vSync,
  output logic [DATA_WIDTH-1:0]        o_lcdData,
  output logic                         o_valid,
  output logic                         o_update,
  output logic [$clog2(NUM_BUFFERS):0] o_fill,
  output logic                         o_overflow,
  output logic                         o_underrun
);
  localparam int PW   = $clog2(NUM_BUFFERS);
  localparam int FW   = PW + 1;
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WW   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW   = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int UW   = $clog2(UPDATE_CYCLES + 1);
  localparam int MAXA = (WORDS_PER_LINE > BLANK_PER_LINE) ? WORDS_PER_LINE : BLANK_PER_LINE;
  localparam int MAXC = (MAXA > BACK_PORCH) ? MAXA : BACK_PORCH;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, WAIT, SEND, BLANK, PORCH} state_e;

  // Input synchronisers and SCK edge detect
  logic [1:0] sck_sync_q, mosi_sync_q, vs_sync_q;
  logic       sck_prev_q;
  logic       sck_rise;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      vs_sync_q   <= 2'b11;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], i_sck};
      mosi_sync_q <= {mosi_sync_q[0], i_mosi};
      vs_sync_q   <= {vs_sync_q[0], i_vSync};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;

  // Writer
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, word;
  logic [WW-1:0]         word_cnt_q;
  logic [PW-1:0]         wr_ptr_q;
  logic                  drop_q;
  logic [FW-1:0]         fill_q;
  logic                  word_done, ring_full, wr_en, line_done, commit, release_buf;
  logic                  overflow_q;

  logic [DATA_WIDTH-1:0] mem_q [NUM_BUFFERS][WORDS_PER_LINE];

  always_comb begin
    word            = shift_q;
    word[bit_cnt_q] = mosi_sync_q[1];
  end

  assign ring_full = (fill_q == FW'(NUM_BUFFERS));
  assign word_done = sck_rise & vs_sync_q[1] & (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign wr_en     = word_done & ~ring_full;
  assign line_done = word_done & (word_cnt_q == WW'(WORDS_PER_LINE - 1));
  assign commit    = line_done & ~drop_q & ~ring_full;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= line_done & (drop_q | ring_full);
      if (!vs_sync_q[1]) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        drop_q     <= 1'b0;
      end else if (sck_rise) begin
        shift_q <= word;
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          bit_cnt_q <= '0;
          if (ring_full) drop_q <= 1'b1;
          if (word_cnt_q == WW'(WORDS_PER_LINE - 1)) begin
            word_cnt_q <= '0;
            drop_q     <= 1'b0;
            if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
          end else begin
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_ptr_q][word_cnt_q] <= word;
  end

  // Reader
  state_e          state_q, state_d;
  logic [CW-1:0]   pkt_q, pkt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   line_q, line_d;
  logic [UW-1:0]   fpkt_q, fpkt_d;
  logic            blk_q, blk_d, uflag_q, uflag_d;
  logic            underrun_d, dispatch;
  logic [DATA_WIDTH-1:0] data_q;
  logic            valid_q, update_q, underrun_q;

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    rd_ptr_d    = rd_ptr_q;
    line_d      = line_q;
    fpkt_d      = fpkt_q;
    blk_d       = blk_q;
    uflag_d     = 1'b0;
    underrun_d  = 1'b0;
    release_buf = 1'b0;
    dispatch    = 1'b0;
    // frame_pkt saturates: only "below UPDATE_CYCLES" is ever observed
    if ((state_q == SEND || state_q == BLANK) && fpkt_q != UW'(UPDATE_CYCLES))
      fpkt_d = fpkt_q + 1'b1;
    case (state_q)
      IDLE: if (i_enable) state_d = WAIT;
      WAIT: begin
        uflag_d  = uflag_q;
        dispatch = 1'b1;
      end
      SEND: begin
        pkt_d = pkt_q + 1'b1;
        if (pkt_q == CW'(WORDS_PER_LINE - 1)) begin
          pkt_d   = '0;
          state_d = BLANK;
          if (!blk_q) begin
            release_buf = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
          end
        end
      end
      BLANK: begin
        pkt_d = pkt_q + 1'b1;
        if (pkt_q == CW'(BLANK_PER_LINE - 1)) begin
          pkt_d = '0;
          if (line_q == LW'(LINES_PER_FRAME - 1)) begin
            state_d = PORCH;
          end else begin
            line_d   = line_q + 1'b1;
            dispatch = 1'b1;
          end
        end
      end
      PORCH: begin
        pkt_d = pkt_q + 1'b1;
        if (pkt_q == CW'(BACK_PORCH - 1)) begin
          pkt_d    = '0;
          line_d   = '0;
          fpkt_d   = '0;
          dispatch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line start decision shared by WAIT and the ends of BLANK/PORCH, so a ready line costs no gap
    if (dispatch) begin
      if (fill_q != '0) begin
        state_d = SEND;
        blk_d   = 1'b0;
      end else begin
`ifdef HDP_STREAMER_BLANK_FILL_EN
        state_d    = SEND;
        blk_d      = 1'b1;
        underrun_d = 1'b1;
`else
        state_d = WAIT;
        if (state_q == WAIT) begin
          underrun_d = ~uflag_q;
          uflag_d    = 1'b1;
        end
`endif
      end
    end
    if (!i_enable) begin
      state_d     = IDLE;
      pkt_d       = '0;
      line_d      = '0;
      fpkt_d      = '0;
      blk_d       = 1'b0;
      uflag_d     = 1'b0;
      underrun_d  = 1'b0;
      release_buf = 1'b0;
      rd_ptr_d    = rd_ptr_q;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      rd_ptr_q   <= '0;
      line_q     <= '0;
      fpkt_q     <= '0;
      blk_q      <= 1'b0;
      uflag_q    <= 1'b0;
      fill_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      rd_ptr_q   <= rd_ptr_d;
      line_q     <= line_d;
      fpkt_q     <= fpkt_d;
      blk_q      <= blk_d;
      uflag_q    <= uflag_d;
      underrun_q <= underrun_d;
      case ({commit, release_buf})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      // RAM read doubles as the output register
      data_q   <= (i_enable && state_q == SEND && !blk_q) ? mem_q[rd_ptr_q][pkt_q[WW-1:0]] : '0;
      valid_q  <= i_enable && state_q == SEND;
      update_q <= i_enable && (state_q == SEND || state_q == BLANK) &&
                  fpkt_q != UW'(UPDATE_CYCLES);
    end
  end

  assign o_lcdData  = data_q;
  assign o_valid    = valid_q;
  assign o_update   = update_q;
  assign o_fill     = fill_q;
  assign o_overflow = overflow_q;
  assign o_underrun = underrun_q;
endmodule

// File: tb/tb_hdp_line_streamer.sv
// Randomised bench for hdp_line_streamer (default build) with a line-queue reference model.
`timescale 1ns/1ps
module tb_hdp_line_streamer;
  localparam int DW = 8, WPL = 4, BPL = 2, LPF = 3, BP = 5, UPD = 7, NB = 4;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, sck = 1'b0, mosi = 1'b0, vs = 1'b1;
  logic [DW-1:0] lcd;
  logic          vld, upd, ovf, unr;
  logic [2:0]    fill;

  always #5 clk = ~clk;

  hdp_line_streamer #(
    .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .BLANK_PER_LINE(BPL), .LINES_PER_FRAME(LPF),
    .BACK_PORCH(BP), .UPDATE_CYCLES(UPD), .NUM_BUFFERS(NB)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sck(sck), .i_mosi(mosi), .i_vSync(vs),
    .o_lcdData(lcd), .o_valid(vld), .o_update(upd), .o_fill(fill),
    .o_overflow(ovf), .o_underrun(unr)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [DW-1:0] got_d[$];
  int            got_c[$];
  int            cyc = 0, upd_cnt = 0, ovf_cnt = 0, ovf_hi = 0, unr_cnt = 0, unr_hi = 0, bad_blank = 0;
  logic          ovf_p = 1'b0, unr_p = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (vld) begin
        got_d.push_back(lcd);
        got_c.push_back(cyc);
      end else if (lcd != '0) bad_blank <= bad_blank + 1;
      if (upd) upd_cnt <= upd_cnt + 1;
      if (ovf) begin
        ovf_hi <= ovf_hi + 1;
        if (!ovf_p) ovf_cnt <= ovf_cnt + 1;
      end
      if (unr) begin
        unr_hi <= unr_hi + 1;
        if (!unr_p) unr_cnt <= unr_cnt + 1;
      end
    end
    ovf_p <= ovf;
    unr_p <= unr;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SPI at f_clk/8, LSB first
  task automatic spi_bit(input logic b);
    mosi = b;
    tick(4);
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic spi_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) spi_bit(w[i]);
  endtask

  // Reference: committed lines queue in order; lines arriving at a full ring are lost
  int            mfill = 0;
  logic [DW-1:0] exp_q[$];

  task automatic send_line();
    logic [DW-1:0] w[WPL];
    for (int i = 0; i < WPL; i++) w[i] = DW'($urandom);
    for (int i = 0; i < WPL; i++) spi_word(w[i]);
    if (mfill < NB) begin
      mfill++;
      for (int i = 0; i < WPL; i++) exp_q.push_back(w[i]);
    end
  endtask

  task automatic replay();
    int n, base, u0, r0, t, off, ue, lf;
    n = exp_q.size() / WPL;
    base = got_d.size();
    u0 = upd_cnt;
    r0 = unr_cnt;
    en = 1'b1;
    t = 0;
    while (got_d.size() < base + n * WPL && t < 400) begin
      tick();
      t++;
    end
    chk("replay_timeout", int'(t < 400), 1);
    tick(40);
    chk("replay_count", got_d.size() - base, n * WPL);
    for (int i = 0; i < n * WPL; i++)
      if (base + i < got_d.size()) chk("replay_data", int'(got_d[base+i]), int'(exp_q[i]));
    for (int l = 0; l < n; l++) begin
      if (base + l * WPL + WPL - 1 < got_c.size()) begin
        off = l * (WPL + BPL) + (l / LPF) * BP;
        chk("line_start", got_c[base+l*WPL] - got_c[base], off);
        chk("line_contig", got_c[base+l*WPL+WPL-1] - got_c[base+l*WPL], WPL - 1);
      end
    end
    ue = 0;
    for (int f = 0; f * LPF < n; f++) begin
      lf = (n - f * LPF < LPF) ? n - f * LPF : LPF;
      ue += (lf * (WPL + BPL) < UPD) ? lf * (WPL + BPL) : UPD;
    end
    chk("update_cycles", upd_cnt - u0, ue);
    chk("underrun_after_drain", unr_cnt - r0, 1);
    chk("fill_drained", int'(fill), 0);
    exp_q.delete();
    mfill = 0;
    en = 1'b0;
    tick(2);
  endtask

  initial begin
    int k, o0, t, n0;
    // Reset state
    tick(3);
    chk("rst_data", int'(lcd), 0);
    chk("rst_valid", int'(vld), 0);
    chk("rst_update", int'(upd), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unr", int'(unr), 0);
    rst = 1'b0;
    tick(3);

    // Live single line with reader already waiting on an empty ring
    en = 1'b1;
    tick(20);
    chk("underrun_empty", unr_cnt, 1);
    chk("no_valid_empty", got_d.size(), 0);
    o0 = upd_cnt;
    send_line();
    t = 0;
    while (got_d.size() < WPL && t < 100) begin
      tick();
      t++;
    end
    tick(20);
    chk("live_count", got_d.size(), WPL);
    for (int i = 0; i < WPL; i++)
      if (i < got_d.size()) chk("live_data", int'(got_d[i]), int'(exp_q[i]));
    chk("live_update", upd_cnt - o0, (WPL + BPL < UPD) ? WPL + BPL : UPD);
    chk("live_underrun", unr_cnt, 2);
    chk("live_fill", int'(fill), 0);
    exp_q.delete();
    mfill = 0;
    en = 1'b0;
    tick(2);

    // Fill with reader off, random line counts incl. overflow
    for (int r = 0; r < 4; r++) begin
      k = (r == 0) ? NB + 1 : $urandom_range(1, NB + 2);
      o0 = ovf_cnt;
      for (int j = 0; j < k; j++) send_line();
      chk("fill_loaded", int'(fill), (k < NB) ? k : NB);
      chk("overflow_pulses", ovf_cnt - o0, (k > NB) ? k - NB : 0);
      replay();
    end

    // Frame align discards the partial line only
    send_line();
    chk("fill_before_vsync", int'(fill), 1);
    spi_word(DW'($urandom));
    spi_word(DW'($urandom));
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom));
    vs = 1'b0;
    tick(6);
    vs = 1'b1;
    tick(4);
    chk("fill_after_vsync", int'(fill), 1);
    send_line();
    chk("fill_after_realign", int'(fill), 2);
    replay();

    // Reset mid-SEND with two lines committed
    send_line();
    send_line();
    chk("fill_pre_reset", int'(fill), 2);
    en = 1'b1;
    t = 0;
    while (!vld && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_seen", int'(vld), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_data", int'(lcd), 0);
    chk("mid_rst_valid", int'(vld), 0);
    chk("mid_rst_update", int'(upd), 0);
    chk("mid_rst_fill", int'(fill), 0);
    en = 1'b0;
    exp_q.delete();
    mfill = 0;
    tick(3);
    rst = 1'b0;
    n0 = got_d.size();
    tick(30);
    chk("idle_after_reset", got_d.size() - n0, 0);
    chk("fill_after_reset", int'(fill), 0);
    send_line();
    replay();

    chk("blank_data_zero", bad_blank, 0);
    chk("ovf_single_cycle", ovf_hi, ovf_cnt);
    chk("unr_single_cycle", unr_hi, unr_cnt);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hdp_line_streamer.md
# hdp_line_streamer

Parametrised SPI-to-HDP line streamer, sitting between the host SPI pixel feed and the LCD HDP data port in the top level. It deserialises SPI pixel data, sampled in the system clock domain, into an N-deep ring of line buffers. It then replays each completed line to the panel as a fixed-cadence packet stream with `o_valid`/`o_update` framing. This generation adds single-clock operation, a configurable buffer depth and line geometry, deterministic underrun and overflow handling, and status flags.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bits per SPI word and per HDP packet
- `WORDS_PER_LINE`, 40, valid packets per line
- `BLANK_PER_LINE`, 4, blank packets after each line
- `LINES_PER_FRAME`, 1280, lines per frame
- `BACK_PORCH`, 24, blank cycles after the last line of a frame
- `UPDATE_CYCLES`, 28, packets at frame start with `o_update` high
- `NUM_BUFFERS`, 4, line buffers in the ring; power of two, ≥2

Ports:
- `i_clock` in 1: system clock; all logic is on its rising edge
- `i_reset` in 1: asynchronous, active-high reset
- `i_enable` in 1: panel in normal mode; enables the reader
- `i_sck` in 1: SPI clock, asynchronous; data is taken on its rising edge
- `i_mosi` in 1: SPI data, asynchronous
- `i_vSync` in 1: active-low frame align, asynchronous
- `o_lcdData` out `DATA_WIDTH`: HDP packet
- `o_valid` out 1: `o_lcdData` carries pixel data
- `o_update` out 1: frame-start update window
- `o_fill` out `clog2(NUM_BUFFERS)+1`: count of committed buffers
- `o_overflow` out 1: one-cycle pulse when a line is dropped
- `o_underrun` out 1: one-cycle pulse when the reader finds no line ready

## Operation
- **Input sync:** `i_sck`, `i_mosi` and `i_vSync` each pass through a 2-flop synchroniser. The SCK rising edge is detected from the synchronised SCK and its registered copy.
- **Writer, bit capture:** on each detected SCK edge, `mosi` goes into bit `bit_cnt` of the shift word, LSB first.
  - `bit_cnt` wraps at `DATA_WIDTH-1`.
  - On wrap, the word is written to `buf[wr_ptr][word_cnt]`.
- **Writer, line completion:** when `word_cnt` reaches `WORDS_PER_LINE-1`, the line is complete.
  - If not flagged dropped, it commits: `fill+1` and `wr_ptr+1` (mod `NUM_BUFFERS`).
  - If flagged dropped, it is not committed and `o_overflow` pulses.
- **Writer, full ring:** a word write with `fill==NUM_BUFFERS` is discarded and flags the current line as dropped.
- **Writer, frame align:** synchronised `vSync` low clears `bit_cnt`, `word_cnt` and the drop flag. The partial line is discarded; committed buffers are untouched.
- **Reader state machine** (IDLE, WAIT, SEND, BLANK, PORCH):
  - IDLE → WAIT when `i_enable`=1.
  - WAIT → SEND when `fill>0`. Otherwise pulse `o_underrun` once per WAIT entry and stay in WAIT.
  - SEND: drive `buf[rd_ptr][pkt]` for `WORDS_PER_LINE` cycles, then go to BLANK. On leaving SEND, release the buffer: `fill-1`, `rd_ptr+1`.
  - BLANK: `BLANK_PER_LINE` cycles of zero data, then `line_cnt+1`. Go to PORCH if `line_cnt==LINES_PER_FRAME-1`, else WAIT.
  - PORCH: `BACK_PORCH` cycles of zero data. Then clear `line_cnt` and `frame_pkt`, and go to WAIT.
- **Update window:** `frame_pkt` counts SEND and BLANK cycles only; `o_update` = `frame_pkt < UPDATE_CYCLES`.
- **Simultaneous commit and release:** `fill` is unchanged.
- **`i_enable` falls:** the reader goes to IDLE next cycle, and `line_cnt`, `frame_pkt` and `pkt` are cleared. `rd_ptr` and `fill` are kept, so a half-sent line stays committed and is resent in full.
- **Reset:** all outputs 0, all pointers, counters and `fill` 0, reader in IDLE. Buffer contents are undefined.

## Timing
- Input latency: SPI edge to the sampled bit is 3 clocks. SCK high and low each need ≥2 clocks, so f_sck ≤ f_clk/4.
- `o_lcdData`, `o_valid` and `o_update` are registered together. The first packet appears 2 clocks after WAIT sees `fill>0`, allowing for the synchronous RAM read.
- Line period is exactly `WORDS_PER_LINE+BLANK_PER_LINE` clocks when no underrun occurs. There are no gap cycles between WAIT→SEND and BLANK→WAIT when a line is ready.
- A committed line is visible to the reader the cycle after commit.
- `o_overflow` and `o_underrun` are single-clock pulses.

## Configuration
- **`HDP_STREAMER_BLANK_FILL_EN` defined:** on underrun, WAIT does not stall.
  - It emits a full black line: `WORDS_PER_LINE` cycles with data 0 and `o_valid`=1, then BLANK as normal.
  - `line_cnt` advances and no buffer is released.
  - Frame timing stays fixed.
- **Undefined:** WAIT stalls until a line is ready, and `frame_pkt` does not advance while stalled.

## Test plan
- Reset mid-SEND with `fill`=2 → all outputs 0 and `fill`=0 next cycle; reader in IDLE.
- Send 1 line of words 0..39 over SPI (f_clk/8) with `i_enable`=1 → 40 valid packets 0..39, then 4 zero blanks; `o_fill` 1→0.
- Fill 4 lines with the reader disabled, then send a 5th → `o_overflow` pulses once, `o_fill`=4; enabling the reader replays lines 1–4 in order.
- Stream 1280 lines back-to-back → `o_update` high for exactly 28 packets at frame start; 24-cycle porch after line 1279; frame period 56344 clocks.
- Starve the reader after 1 line → `o_underrun` pulses once. With the macro, a 40-packet zero line with `o_valid`=1 follows; without it, the reader stalls with `o_valid`=0.
- Assert `i_vSync` low after 17 bits → the partial word is discarded, the next 32 bits form word 0 of a new line, and `o_fill` is unchanged.
